// File: rtl/audio_sample_ctrl_pkg.sv
// audio_pkg: shared types and constants for the audio sample sequencer.
//   audio_state_e  : audio FSM state encoding (exposed on the debug port)
//   FILT_LPF/HPF   : filt_type encodings
//   DEFAULT_*      : default word width, pot channel count and sample rate
package audio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_PUSH    = 3'd4
  } audio_state_e;

  localparam logic FILT_LPF = 1'b0;
  localparam logic FILT_HPF = 1'b1;

  localparam int DEFAULT_N        = 10;
  localparam int DEFAULT_CHANNELS = 2;
  localparam int DEFAULT_FS_HZ    = 44100;

endpackage

// File: rtl/audio_sample_ctrl_sync_rise.sv
// sync_rise: 2-FF synchroniser for an asynchronous level, plus a one-cycle
// rise pulse derived from the synchronised level.
//   clk, rst_n : clock, async active-low reset
//   async_i    : asynchronous input level
//   level_o    : synchronised level
//   rise_o     : high for one cycle when level_o goes 0 -> 1
module sync_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_i};
      prev_q <= sync_q[1];
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~prev_q;

endmodule

// File: rtl/audio_sample_ctrl.sv
// audio_sample_ctrl: sample sequencer between the ADC front ends, the IIR
// filter datapath and the PWM DAC.
//   adc_sample/adc_valid   : audio ADC word and async valid level
//   pot_sample/pot_valid   : packed pot ADC words and async valid level
//   pot_sel                : pot channel to average
//   filt_type              : async LPF/HPF switch, latched at capture
//   clr_flags              : clears overrun/underrun/timeout
//   x_hist/y_prev/filt_type_q : operands presented to the filter
//   filt_start/filt_done/filt_result : filter compute handshake
//   pwm_ready/duty         : async PWM request level and duty word
//   fifo_level             : output FIFO occupancy
//   overrun/underrun/timeout : sticky status flags
//   dbg_state_o            : audio FSM state
//
// Filter handshake: filt_start is a single-cycle request issued once per
// captured sample; the filter answers with a single-cycle filt_done carrying
// filt_result. A request without an answer within TIMEOUT cycles is closed
// by the sequencer itself, reusing y_prev as the result.
module audio_sample_ctrl
  import audio_pkg::*;
#(
  parameter int N         = DEFAULT_N,
  parameter int CHANNELS  = DEFAULT_CHANNELS,
  parameter int HIST      = 2,
  parameter int OUT_DEPTH = 4,
  parameter int AVG_LOG2  = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N-1:0]                  adc_sample,
  input  logic                          adc_valid,
  input  logic [CHANNELS*N-1:0]         pot_sample,
  input  logic                          pot_valid,
  input  logic [$clog2(CHANNELS)-1:0]   pot_sel,
  input  logic                          filt_type,
  input  logic                          clr_flags,
  output logic [HIST*N-1:0]             x_hist,
  output logic [N-1:0]                  y_prev,
  output logic                          filt_type_q,
  output logic [N-1:0]                  pot_avg,
  output logic                          filt_start,
  input  logic                          filt_done,
  input  logic [N-1:0]                  filt_result,
  input  logic                          pwm_ready,
  output logic [N-1:0]                  duty,
  output logic [$clog2(OUT_DEPTH):0]    fifo_level,
  output logic                          overrun,
  output logic                          underrun,
  output logic                          timeout,
  output audio_state_e                  dbg_state_o
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ACC_W = N + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [N-1:0] MIDSCALE = {1'b1, {(N-1){1'b0}}};

  // Synchronisers
  logic adc_rise, pot_rise, pwm_rise, ftype_s;
  logic adc_lvl, pot_lvl, pwm_lvl, ftype_rise;
  logic unused_sync;

  sync_rise u_sync_adc   (.clk(clk), .rst_n(reset_n), .async_i(adc_valid), .level_o(adc_lvl),   .rise_o(adc_rise));
  sync_rise u_sync_pot   (.clk(clk), .rst_n(reset_n), .async_i(pot_valid), .level_o(pot_lvl),   .rise_o(pot_rise));
  sync_rise u_sync_pwm   (.clk(clk), .rst_n(reset_n), .async_i(pwm_ready), .level_o(pwm_lvl),   .rise_o(pwm_rise));
  sync_rise u_sync_ftype (.clk(clk), .rst_n(reset_n), .async_i(filt_type), .level_o(ftype_s),   .rise_o(ftype_rise));

  assign unused_sync = ^{adc_lvl, pot_lvl, pwm_lvl, ftype_rise};

  // State
  audio_state_e        state_q, state_d;
  logic [N-1:0]        cap_q, cap_d;
  logic [N-1:0]        pend_q, pend_d;
  logic                pend_valid_q, pend_valid_d;
  logic [HIST*N-1:0]   hist_q, hist_d;
  logic                ftype_q, ftype_d;
  logic [TMO_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [N-1:0]        result_q, result_d;
  logic [N-1:0]        y_prev_q, y_prev_d;
  logic [N-1:0]        mem_q [OUT_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [N-1:0]        duty_q, duty_d;
  logic                overrun_q, overrun_d, underrun_q, underrun_d, timeout_q, timeout_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N-1:0]        avg_q, avg_d;
  logic [SEL_W-1:0]    sel_prev_q;
  logic [N-1:0]        sel_word;

  logic ovr_adc, ovr_fifo, udr_set, tmo_set, push, pop;
  logic fifo_empty, fifo_full, bypass, do_write, do_read;

  // Audio FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (adc_rise || pend_valid_q) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_START;
      ST_START:   state_d = ST_WAIT;
      ST_WAIT:    if (filt_done || (wait_cnt_q == TMO_W'(TIMEOUT - 1))) state_d = ST_PUSH;
      ST_PUSH:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Capture, pending, history and filter handshake datapath
  always_comb begin
    cap_d        = cap_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    hist_d       = hist_q;
    ftype_d      = ftype_q;
    wait_cnt_d   = wait_cnt_q;
    result_d     = result_q;
    y_prev_d     = y_prev_q;
    ovr_adc      = 1'b0;
    tmo_set      = 1'b0;
    push         = 1'b0;

    // The word to capture is chosen when leaving IDLE: a pending sample is
    // older than a fresh edge, so it goes first and the fresh sample takes
    // its place in the pending slot.
    if (state_q == ST_IDLE) begin
      if (pend_valid_q) begin
        cap_d        = pend_q;
        pend_valid_d = adc_rise;
        if (adc_rise) pend_d = adc_sample;
      end else if (adc_rise) begin
        cap_d = adc_sample;
      end
    end else if (adc_rise) begin
      pend_d       = adc_sample;
      pend_valid_d = 1'b1;
      ovr_adc      = pend_valid_q;
    end

    case (state_q)
      ST_CAPTURE: begin
        hist_d  = {hist_q[(HIST-1)*N-1:0], cap_q};
        ftype_d = ftype_s;
      end
      ST_START: wait_cnt_d = '0;
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + TMO_W'(1);
        if (filt_done) begin
          result_d = filt_result;
        end else if (wait_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          result_d = y_prev_q;
          tmo_set  = 1'b1;
        end
      end
      ST_PUSH: begin
        y_prev_d = result_q;
        push     = 1'b1;
      end
      default: ;
    endcase
  end

  // Output FIFO
  always_comb begin
    pop        = pwm_rise;
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LVL_W'(OUT_DEPTH));
    // Push into an empty FIFO while popping hands the word straight to duty.
    bypass     = push && pop && fifo_empty;
    do_write   = push && !bypass && (!fifo_full || pop);
    do_read    = pop && !fifo_empty;
    ovr_fifo   = push && fifo_full && !pop;
    udr_set    = pop && fifo_empty && !push;

    duty_d = duty_q;
    if (bypass)       duty_d = result_q;
    else if (do_read) duty_d = mem_q[rd_ptr_q];

    wr_ptr_d = do_write ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_read  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q + LVL_W'(do_write) - LVL_W'(do_read);
  end

  // Sticky flags: a setting event beats a simultaneous clear.
  always_comb begin
    overrun_d  = clr_flags ? 1'b0 : overrun_q;
    underrun_d = clr_flags ? 1'b0 : underrun_q;
    timeout_d  = clr_flags ? 1'b0 : timeout_q;
    if (ovr_adc || ovr_fifo) overrun_d  = 1'b1;
    if (udr_set)             underrun_d = 1'b1;
    if (tmo_set)             timeout_d  = 1'b1;
  end

  // Pot averaging
  always_comb begin
    sel_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (SEL_W'(c) == pot_sel) sel_word = pot_sample[c*N +: N];
    end
    acc_sum = acc_q + ACC_W'(sel_word);
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    avg_d   = avg_q;
    // A channel switch restarts the window so averages never mix channels.
    if (pot_sel != sel_prev_q) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (pot_rise) begin
      if (cnt_q == CNT_W'((1 << AVG_LOG2) - 1)) begin
        avg_d = N'(acc_sum >> AVG_LOG2);
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cap_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      hist_q       <= '0;
      ftype_q      <= FILT_LPF;
      wait_cnt_q   <= '0;
      result_q     <= '0;
      y_prev_q     <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      duty_q       <= MIDSCALE;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
      timeout_q    <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      avg_q        <= '0;
      sel_prev_q   <= '0;
    end else begin
      state_q      <= state_d;
      cap_q        <= cap_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      hist_q       <= hist_d;
      ftype_q      <= ftype_d;
      wait_cnt_q   <= wait_cnt_d;
      result_q     <= result_d;
      y_prev_q     <= y_prev_d;
      if (do_write) mem_q[wr_ptr_q] <= result_q;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      duty_q       <= duty_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
      timeout_q    <= timeout_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      avg_q        <= avg_d;
      sel_prev_q   <= pot_sel;
    end
  end

  assign x_hist      = hist_q;
  assign y_prev      = y_prev_q;
  assign filt_type_q = ftype_q;
  assign pot_avg     = avg_q;
  assign filt_start  = (state_q == ST_START);
  assign duty        = duty_q;
  assign fifo_level  = level_q;
  assign overrun     = overrun_q;
  assign underrun    = underrun_q;
  assign timeout     = timeout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_audio_sample_ctrl.sv
module tb_audio_sample_ctrl;
  import audio_pkg::*;

  localparam int N = 10, CHANNELS = 2, HIST = 2, OUT_DEPTH = 4, AVG_LOG2 = 2, TIMEOUT = 64;

  // Clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]          adc_sample = '0;
  logic                  adc_valid = 1'b0;
  logic [CHANNELS*N-1:0] pot_sample = '0;
  logic                  pot_valid = 1'b0;
  logic                  pot_sel = 1'b0;
  logic                  filt_type = 1'b0;
  logic                  clr_flags = 1'b0;
  logic [HIST*N-1:0]     x_hist;
  logic [N-1:0]          y_prev;
  logic                  filt_type_q;
  logic [N-1:0]          pot_avg;
  logic                  filt_start;
  logic                  filt_done = 1'b0;
  logic [N-1:0]          filt_result = '0;
  logic                  pwm_ready = 1'b0;
  logic [N-1:0]          duty;
  logic [2:0]            fifo_level;
  logic                  overrun, underrun, timeout;
  audio_state_e          dbg_state;

  audio_sample_ctrl #(.N(N), .CHANNELS(CHANNELS), .HIST(HIST), .OUT_DEPTH(OUT_DEPTH),
                      .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .adc_sample(adc_sample), .adc_valid(adc_valid),
    .pot_sample(pot_sample), .pot_valid(pot_valid), .pot_sel(pot_sel),
    .filt_type(filt_type), .clr_flags(clr_flags), .x_hist(x_hist), .y_prev(y_prev),
    .filt_type_q(filt_type_q), .pot_avg(pot_avg), .filt_start(filt_start),
    .filt_done(filt_done), .filt_result(filt_result), .pwm_ready(pwm_ready),
    .duty(duty), .fifo_level(fifo_level), .overrun(overrun), .underrun(underrun),
    .timeout(timeout), .dbg_state_o(dbg_state)
  );

  // Scoreboard / reference model
  int n_checks = 0;
  int n_pass = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] m_duty = 10'h200;
  logic [N-1:0] m_yprev = '0;
  logic m_ovr = 1'b0, m_udr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Filter model and filt_start monitor
  int start_count = 0;
  int double_count = 0;
  logic fs_prev = 1'b0;
  bit resp_en = 1'b1;
  int resp_delay = 5;

  always @(negedge clk) begin
    if (filt_start && !fs_prev) start_count++;
    if (filt_start && fs_prev) double_count++;
    fs_prev = filt_start;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (filt_start && resp_en) begin
        repeat (resp_delay - 1) @(negedge clk);
        filt_result = x_hist[N-1:0] + 10'd1;
        filt_done = 1'b1;
        @(negedge clk);
        filt_done = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic adc_pulse(input logic [N-1:0] s, input int hi, input int lo);
    adc_sample = s;
    adc_valid = 1'b1;
    tick(hi);
    adc_valid = 1'b0;
    tick(lo);
  endtask

  task automatic pot_pulse(input logic [N-1:0] ch1, input logic [N-1:0] ch0);
    pot_sample = {ch1, ch0};
    pot_valid = 1'b1;
    tick(2);
    pot_valid = 1'b0;
    tick(3);
  endtask

  task automatic run_until(input int target, input string tag);
    int budget = 400;
    while (start_count < target && budget > 0) begin tick(1); budget--; end
    while (dbg_state != ST_IDLE && budget > 0) begin tick(1); budget--; end
    check({tag, "_in_time"}, 32'(budget > 0), 32'd1);
  endtask

  task automatic wait_state(input audio_state_e st, input string tag);
    int budget = 100;
    while (dbg_state != st && budget > 0) begin tick(1); budget--; end
    check({tag, "_reached"}, 32'(budget > 0), 32'd1);
  endtask

  task automatic model_push(input logic [N-1:0] r);
    m_yprev = r;
    if (exp_q.size() < OUT_DEPTH) exp_q.push_back(r);
    else m_ovr = 1'b1;
  endtask

  task automatic pwm_pop(input string tag);
    pwm_ready = 1'b1;
    tick(2);
    pwm_ready = 1'b0;
    tick(3);
    if (exp_q.size() > 0) m_duty = exp_q.pop_front();
    else m_udr = 1'b1;
    check(tag, 32'(duty), 32'(m_duty));
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    m_ovr = 1'b0;
    m_udr = 1'b0;
    tick(1);
  endtask

  initial begin
    logic [N-1:0] a, b, c, s, w0;
    logic [N-1:0] ch1_words [4];
    int base, wait_cycles, npop, sum;

    // Reset state
    tick(3);
    check("rst_duty_in_reset", 32'(duty), 32'h200);
    reset_n = 1'b1;
    tick(2);
    check("rst_x_hist", 32'(x_hist), 32'h0);
    check("rst_y_prev", 32'(y_prev), 32'h0);
    check("rst_pot_avg", 32'(pot_avg), 32'h0);
    check("rst_level", 32'(fifo_level), 32'h0);
    check("rst_duty", 32'(duty), 32'h200);
    check("rst_flags", {29'd0, overrun, underrun, timeout}, 32'h0);
    check("rst_ftype", 32'(filt_type_q), 32'h0);
    check("rst_start", 32'(filt_start), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Three samples through the filter
    adc_pulse(10'h100, 2, 3); run_until(1, "t1_s1"); model_push(10'h101);
    adc_pulse(10'h200, 2, 3); run_until(2, "t1_s2"); model_push(10'h201);
    filt_type = FILT_HPF;
    tick(4);
    adc_pulse(10'h300, 2, 3); run_until(3, "t1_s3"); model_push(10'h301);
    check("t1_x_hist", 32'(x_hist), 32'({10'h200, 10'h300}));
    check("t1_y_prev", 32'(y_prev), 32'h301);
    check("t1_level", 32'(fifo_level), 32'd3);
    check("t1_starts", 32'(start_count), 32'd3);
    check("t1_start_width", 32'(double_count), 32'd0);
    check("t1_ftype", 32'(filt_type_q), 32'(FILT_HPF));
    check("t1_overrun", 32'(overrun), 32'h0);
    for (int i = 0; i < 3; i++) pwm_pop("t1_pop");
    check("t1_level_empty", 32'(fifo_level), 32'd0);

    // Fill past full, then drain past empty
    for (int i = 0; i < 6; i++) begin
      adc_pulse(10'h054, 2, 3);
      run_until(4 + i, "t2_push");
      model_push(10'h055);
    end
    check("t2_level_full", 32'(fifo_level), 32'd4);
    check("t2_overrun", 32'(overrun), 32'(m_ovr));
    for (int i = 0; i < 4; i++) pwm_pop("t2_pop");
    check("t2_no_underrun_yet", 32'(underrun), 32'h0);
    pwm_pop("t2_pop_empty_held");
    check("t2_underrun", 32'(underrun), 32'(m_udr));
    clear_flags();
    check("t2_flags_cleared", {30'd0, overrun, underrun}, 32'h0);

    // Filter timeout
    resp_en = 1'b0;
    base = start_count;
    wait_cycles = 0;
    adc_sample = 10'h123;
    adc_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (i == 2) adc_valid = 1'b0;
      if (dbg_state == ST_WAIT) wait_cycles++;
      if (wait_cycles > 0 && dbg_state == ST_IDLE) break;
    end
    model_push(m_yprev);
    check("t3_wait_cycles", 32'(wait_cycles), 32'(TIMEOUT));
    check("t3_timeout", 32'(timeout), 32'h1);
    check("t3_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("t3_level", 32'(fifo_level), 32'd1);
    check("t3_y_prev", 32'(y_prev), 32'(m_yprev));
    check("t3_x0", 32'(x_hist[N-1:0]), 32'h123);
    pwm_pop("t3_pop");
    clear_flags();
    check("t3_timeout_cleared", 32'(timeout), 32'h0);
    resp_en = 1'b1;

    // Pot averaging on channel 1, then channel switch mid-window
    pot_sel = 1'b1;
    tick(2);
    ch1_words = '{10'h3FF, 10'h3FD, 10'h3FF, 10'h3FD};
    for (int i = 0; i < 4; i++) begin
      pot_pulse(ch1_words[i], N'($urandom_range(0, 1023)));
      if (i == 2) check("t4_avg_not_yet", 32'(pot_avg), 32'h0);
    end
    check("t4_avg", 32'(pot_avg), 32'h3FE);
    pot_pulse(N'($urandom_range(0, 1023)), N'($urandom_range(0, 1023)));
    pot_pulse(N'($urandom_range(0, 1023)), N'($urandom_range(0, 1023)));
    pot_sel = 1'b0;
    tick(2);
    check("t4_avg_held", 32'(pot_avg), 32'h3FE);
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      w0 = N'($urandom_range(0, 1023));
      sum += int'(w0);
      pot_pulse(N'($urandom_range(0, 1023)), w0);
      if (i == 2) check("t4_avg_held_window", 32'(pot_avg), 32'h3FE);
    end
    check("t4_avg_ch0", 32'(pot_avg), 32'(sum / 4));

    // Pending sample overwrite while waiting on the filter
    resp_delay = 20;
    clear_flags();
    a = 10'h0AA; b = 10'h0BB; c = 10'h0CC;
    base = start_count;
    adc_pulse(a, 2, 3);
    wait_state(ST_WAIT, "t5_wait");
    adc_pulse(b, 2, 2);
    adc_pulse(c, 2, 2);
    tick(3);
    check("t5_still_wait", 32'(dbg_state), 32'(ST_WAIT));
    check("t5_overrun", 32'(overrun), 32'h1);
    run_until(base + 2, "t5_done");
    model_push(a + 10'd1);
    model_push(c + 10'd1);
    m_ovr = 1'b1;
    check("t5_x_hist", 32'(x_hist), 32'({a, c}));
    check("t5_starts", 32'(start_count), 32'(base + 2));
    check("t5_level", 32'(fifo_level), 32'd2);
    pwm_pop("t5_pop_a");
    pwm_pop("t5_pop_c");
    resp_delay = 5;

    // Reset in WAIT with two FIFO entries
    base = start_count;
    adc_pulse(10'h111, 2, 3); run_until(base + 1, "t6_s1"); model_push(10'h112);
    adc_pulse(10'h222, 2, 3); run_until(base + 2, "t6_s2"); model_push(10'h223);
    check("t6_level_before", 32'(fifo_level), 32'd2);
    resp_en = 1'b0;
    adc_pulse(10'h333, 2, 3);
    wait_state(ST_WAIT, "t6_wait");
    reset_n = 1'b0;
    tick(1);
    check("t6_duty_reset", 32'(duty), 32'h200);
    check("t6_level_reset", 32'(fifo_level), 32'd0);
    reset_n = 1'b1;
    exp_q.delete();
    m_duty = 10'h200; m_yprev = '0; m_ovr = 1'b0; m_udr = 1'b0;
    base = start_count;
    tick(30);
    check("t6_no_start", 32'(start_count), 32'(base));
    check("t6_state", 32'(dbg_state), 32'(ST_IDLE));
    check("t6_x_hist", 32'(x_hist), 32'h0);
    check("t6_y_prev", 32'(y_prev), 32'h0);
    check("t6_flags", {29'd0, overrun, underrun, timeout}, 32'h0);
    resp_en = 1'b1;
    adc_pulse(10'h321, 2, 3); run_until(base + 1, "t6_after"); model_push(10'h322);
    check("t6_x0_after", 32'(x_hist[N-1:0]), 32'h321);
    pwm_pop("t6_pop");

    // Randomised transactions against the queue model
    clear_flags();
    base = start_count;
    for (int i = 0; i < 10; i++) begin
      s = N'($urandom_range(0, 1023));
      adc_pulse(s, 2, 3);
      run_until(base + i + 1, "rnd_tx");
      model_push(s + 10'd1);
      check("rnd_y_prev", 32'(y_prev), 32'(m_yprev));
      npop = int'($urandom_range(0, 2));
      for (int k = 0; k < npop; k++) pwm_pop("rnd_pop");
    end
    check("rnd_level", 32'(fifo_level), 32'(exp_q.size()));
    check("rnd_overrun", 32'(overrun), 32'(m_ovr));
    check("rnd_underrun", 32'(underrun), 32'(m_udr));
    check("rnd_start_width", 32'(double_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
